// File: rtl/mult_arb_pkg.sv
// Shared types and widths for mult_arbiter.
// Optional feature macro: MULT_ARB_RR_EN (round-robin arbitration).
package mult_arb_pkg;

   localparam int OP_W   = 4;
   localparam int PROD_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/four_bit_multiplier.sv
// Unsigned 4x4 -> 8 bit combinational multiplier shared by mult_arbiter.
module four_bit_multiplier (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] product
);

   assign product = {4'b0000, a} * {4'b0000, b};

endmodule

// File: rtl/mult_arbiter.sv
// Arbitrates NREQ requesters onto one four_bit_multiplier and returns product + id.
// Define MULT_ARB_RR_EN for round-robin; otherwise the lowest index wins.
module mult_arbiter
   import mult_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [OP_W*NREQ-1:0] req_a,
   input  logic [OP_W*NREQ-1:0] req_b,
   output logic [NREQ-1:0]      req_ready,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [PROD_W-1:0]    rsp_product,
   output logic [IDW-1:0]       rsp_id,
   output logic                 busy
);

   state_t              state_q, state_d;
   logic [OP_W-1:0]     op_a_q, op_a_d;
   logic [OP_W-1:0]     op_b_q, op_b_d;
   logic [IDW-1:0]      id_q, id_d;
   logic [PROD_W-1:0]   prod_q, prod_d;
   logic [PROD_W-1:0]   mult_out;
   logic [IDW:0]        pick;
   logic                found;
   logic [IDW-1:0]      gnt;

   // Returns {found, index}: first set bit of v searching upward from p, wrapping.
   function automatic logic [IDW:0] arb_pick(input logic [NREQ-1:0] v, input logic [IDW-1:0] p);
      logic           hit;
      logic [IDW-1:0] g;
      int             idx;
      hit = 1'b0;
      g   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(p) + k) % NREQ;
         if (!hit && v[idx]) begin
            hit = 1'b1;
            g   = IDW'(idx);
         end
      end
      return {hit, g};
   endfunction

`ifdef MULT_ARB_RR_EN
   logic [IDW-1:0] ptr_q, ptr_d;

   assign pick  = arb_pick(req_valid, ptr_q);
   assign ptr_d = (found && state_q == IDLE)
                ? ((gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1)
                : ptr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end
`else
   assign pick = arb_pick(req_valid, '0);
`endif

   assign {found, gnt} = pick;

   four_bit_multiplier u_mult (
      .a       (op_a_q),
      .b       (op_b_q),
      .product (mult_out)
   );

   always_comb begin
      state_d   = state_q;
      op_a_d    = op_a_q;
      op_b_d    = op_b_q;
      id_d      = id_q;
      prod_d    = prod_q;
      req_ready = '0;
      case (state_q)
         IDLE: begin
            if (found) begin
               req_ready[gnt] = 1'b1;
               op_a_d         = req_a[gnt*OP_W +: OP_W];
               op_b_d         = req_b[gnt*OP_W +: OP_W];
               id_d           = gnt;
               state_d        = CALC;
            end
         end
         CALC: begin
            prod_d  = mult_out;
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         op_a_q  <= '0;
         op_b_q  <= '0;
         id_q    <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         id_q    <= id_d;
         prod_q  <= prod_d;
      end
   end

   assign rsp_valid   = (state_q == RESP);
   assign busy        = (state_q != IDLE);
   assign rsp_product = prod_q;
   assign rsp_id      = id_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed + randomized bench for mult_arbiter against a transaction-level model.
module tb_mult_arbiter;

   localparam int NREQ = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [4*NREQ-1:0] req_a;
   logic [4*NREQ-1:0] req_b;
   logic [NREQ-1:0]   req_ready;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [7:0]        rsp_product;
   logic [1:0]        rsp_id;
   logic              busy;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int ptr_m    = 0;

   mult_arbiter #(.NREQ(NREQ)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_ready   (req_ready),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_product (rsp_product),
      .rsp_id      (rsp_id),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference arbitration: first requester at or after the model pointer (or 0).
   function automatic int model_grant(input logic [NREQ-1:0] v);
      int start;
`ifdef MULT_ARB_RR_EN
      start = ptr_m;
`else
      start = 0;
`endif
      for (int k = 0; k < NREQ; k++)
         if (v[(start + k) % NREQ]) return (start + k) % NREQ;
      return -1;
   endfunction

   // One full transaction from IDLE: grant, CALC, RESP (with stall), handshake, idle.
   task automatic serve(input string tag, input logic [NREQ-1:0] v, input logic [15:0] a,
                        input logic [15:0] b, input int stall, input logic [NREQ-1:0] extra);
      int g, ai, bi, ep;
      logic [NREQ-1:0] rest;
      g    = model_grant(v);
      ai   = int'(a[4*g +: 4]);
      bi   = int'(b[4*g +: 4]);
      ep   = ai * bi;
      rest = (v & ~(NREQ'(1) << g)) | extra;
      req_valid = v;
      req_a     = a;
      req_b     = b;
      rsp_ready = (stall == 0);
      #1;
      check({tag, "_ready"}, 32'(req_ready), 32'(1 << g));
      @(posedge clk); #1;
      req_valid = rest;
      #1;
      check({tag, "_calc_busy"}, 32'(busy), 32'd1);
      check({tag, "_calc_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "_calc_ready"}, 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_product"}, 32'(rsp_product), 32'(ep));
      check({tag, "_id"}, 32'(rsp_id), 32'(g));
      check({tag, "_rsp_ready"}, 32'(req_ready), 32'd0);
      for (int s = 0; s < stall; s++) begin
         @(posedge clk); #1;
         check({tag, "_stall_valid"}, 32'(rsp_valid), 32'd1);
         check({tag, "_stall_product"}, 32'(rsp_product), 32'(ep));
         check({tag, "_stall_id"}, 32'(rsp_id), 32'(g));
         check({tag, "_stall_ready"}, 32'(req_ready), 32'd0);
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "_done_busy"}, 32'(busy), 32'd0);
      check({tag, "_done_ready"}, 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
`ifdef MULT_ARB_RR_EN
      ptr_m = (g + 1) % NREQ;
`endif
      $display("txn %s id=%0d a=%0d b=%0d product=%0d stall=%0d", tag, g, ai, bi, rsp_product, stall);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      #1;
      check("rst_valid", 32'(rsp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_product", 32'(rsp_product), 32'd0);
      check("rst_id", 32'(rsp_id), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst_busy", 32'(busy), 32'd0);

      // Round-robin (or fixed priority) with all requesters valid.
      for (int i = 0; i < 5; i++)
         serve("rr", 4'b1111, 16'h4321 + 16'(i), 16'h8765, 0, 4'b0000);

      serve("single", 4'b0100, 16'h0700, 16'h0900, 0, 4'b0000);

      // Grant follows a request that drops in the cycle it would be granted.
      req_valid = 4'b0100;
      #1;
      check("reeval_first", 32'(req_ready), 32'b0100);
      req_valid = 4'b1000;
      #1;
      check("reeval_second", 32'(req_ready), 32'b1000);
      serve("reeval", 4'b1000, 16'hF000, 16'hF000, 0, 4'b0000);

      serve("bp", 4'b0110, 16'h0DB0, 16'h0EC0, 10, 4'b0000);
      serve("withdraw", 4'b0001, 16'h0005, 16'h0003, 2, 4'b0010);

      // Reset while in CALC drops the transaction.
      req_valid = 4'b0010;
      req_a     = 16'h00A0;
      req_b     = 16'h00B0;
      @(posedge clk); #1;
      req_valid = '0;
      check("midrst_calc_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check("midrst_valid", 32'(rsp_valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_product", 32'(rsp_product), 32'd0);
      check("midrst_id", 32'(rsp_id), 32'd0);
      ptr_m = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("midrst_no_stale", 32'(rsp_valid), 32'd0);
      end
      serve("post_midrst", 4'b1111, 16'h1234, 16'h5678, 0, 4'b0000);

      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            serve("sweep", 4'b0001, 16'(a), 16'(b), 0, 4'b0000);

      for (int i = 0; i < 40; i++)
         serve("rand", 4'($urandom_range(1, 15)), 16'($urandom), 16'($urandom),
               int'($urandom_range(0, 3)), 4'b0000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
